// File: rtl/bot_io_pkg.sv
// bot_io_pkg: PicoBlaze I/O map addresses, interrupt FSM encoding and helpers.
// Revision: 1.0
`default_nettype none
package bot_io_pkg;

    localparam logic [7:0] PORT_PENDING  = 8'h10;
    localparam logic [7:0] PORT_MASK     = 8'h11;
    localparam logic [7:0] PORT_VECTOR   = 8'h12;
    localparam logic [7:0] PORT_EOI      = 8'h13;
    localparam logic [7:0] PORT_OUT_BASE = 8'h20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Index of the lowest set bit; bit 0 is the highest priority source.
    function automatic logic [7:0] lowest_set(input logic [7:0] v);
        lowest_set = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 8'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bot_io_irq.sv
// bot_io_irq: PENDING/MASK/VECTOR registers and interrupt request FSM.
// Revision: 1.0 -- edge/level source detection selected by BOT_IO_IRQ_EDGE_EN.
`default_nettype none
module bot_io_irq
    import bot_io_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             wr,
    input  logic [7:0]       port_id,
    input  logic [N_IRQ-1:0] wdata,
    input  logic             interrupt_ack,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic [7:0]       vector,
    output logic             interrupt
);

    logic [1:0]       state;
    logic [N_IRQ-1:0] irq_event;
    logic [N_IRQ-1:0] masked;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] ack_clr;
    logic [7:0]       sel;
    logic             ack_fire;
    logic             eoi;

`ifdef BOT_IO_IRQ_EDGE_EN
    logic [N_IRQ-1:0] irq_prev;
    always_ff @(posedge clk) begin
        irq_prev <= irq_src;
    end
    assign irq_event = irq_src & ~irq_prev;
`else
    assign irq_event = irq_src;
`endif

    assign masked   = pending & mask;
    assign sel      = lowest_set(8'(masked));
    assign ack_fire = (state == ST_REQ) && interrupt_ack && (|masked);
    assign eoi      = wr && (port_id == PORT_EOI);
    assign w1c      = (wr && (port_id == PORT_PENDING)) ? wdata : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_clr[i] = ack_fire && (sel == 8'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
            mask    <= '0;
            vector  <= 8'h00;
            state   <= ST_IDLE;
        end else begin
            // A new source event outranks any clear in the same cycle.
            pending <= (pending & ~w1c & ~ack_clr) | irq_event;
            if (wr && (port_id == PORT_MASK)) mask <= wdata;
            case (state)
                ST_IDLE: begin
                    if (|masked) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack_fire) begin
                        vector <= sel;
                        state  <= ST_SERVICE;
                    end else if (!(|masked)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign interrupt = (state == ST_REQ);

endmodule
`default_nettype wire

// File: rtl/bot_io_ctrl.sv
// bot_io_ctrl: PicoBlaze I/O decoder with input/output ports, interrupt controller and baud tick.
// Revision: 1.0 -- define BOT_IO_IRQ_EDGE_EN for rising-edge interrupt sources (default: level).
`default_nettype none
module bot_io_ctrl
    import bot_io_pkg::*;
#(
    parameter int N_IN     = 8,
    parameter int N_OUT    = 8,
    parameter int N_IRQ    = 4,
    parameter int BAUD_DIV = 54
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               k_write_strobe,
    input  logic               read_strobe,
    input  logic               interrupt_ack,
    output logic [7:0]         in_port,
    output logic               interrupt,
    input  logic [N_IRQ-1:0]   irq_src,
    input  logic [8*N_IN-1:0]  in_data,
    output logic [N_IN-1:0]    rd_pulse,
    output logic [8*N_OUT-1:0] out_data,
    output logic [N_OUT-1:0]   out_wr,
    output logic               en_16_x_baud
);

    logic             wr;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [7:0]       vector;
    logic [7:0]       rd_mux;
    logic [7:0]       baud_cnt;

    assign wr = write_strobe | k_write_strobe;

    bot_io_irq #(
        .N_IRQ(N_IRQ)
    ) u_irq (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_src      (irq_src),
        .wr           (wr),
        .port_id      (port_id),
        .wdata        (out_port[N_IRQ-1:0]),
        .interrupt_ack(interrupt_ack),
        .pending      (pending),
        .mask         (mask),
        .vector       (vector),
        .interrupt    (interrupt)
    );

    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < N_IN; i++) begin
            if (port_id == 8'(i)) rd_mux = in_data[i*8 +: 8];
        end
        case (port_id)
            PORT_PENDING: rd_mux = 8'(pending);
            PORT_MASK:    rd_mux = 8'(mask);
            PORT_VECTOR:  rd_mux = vector;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_port  <= 8'h00;
            rd_pulse <= '0;
            out_data <= '0;
            out_wr   <= '0;
        end else begin
            in_port <= rd_mux;
            for (int i = 0; i < N_IN; i++) begin
                rd_pulse[i] <= read_strobe && (port_id == 8'(i));
            end
            for (int i = 0; i < N_OUT; i++) begin
                out_wr[i] <= wr && (port_id == PORT_OUT_BASE + 8'(i));
                if (wr && (port_id == PORT_OUT_BASE + 8'(i))) begin
                    out_data[i*8 +: 8] <= out_port;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            baud_cnt     <= 8'd0;
            en_16_x_baud <= 1'b0;
        end else begin
            en_16_x_baud <= (baud_cnt == 8'(BAUD_DIV - 1));
            baud_cnt     <= (baud_cnt == 8'(BAUD_DIV - 1)) ? 8'd0 : baud_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bot_io_ctrl.sv
// tb_bot_io_ctrl: directed self-checking bench for bot_io_ctrl with default parameters.
// Revision: 1.0
`default_nettype none
module tb_bot_io_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  port_id = 8'h00;
    logic [7:0]  out_port = 8'h00;
    logic        write_strobe = 1'b0;
    logic        k_write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic        interrupt_ack = 1'b0;
    logic [7:0]  in_port;
    logic        interrupt;
    logic [3:0]  irq_src = 4'h0;
    logic [63:0] in_data = 64'h7766_5544_33C3_1100;
    logic [7:0]  rd_pulse;
    logic [63:0] out_data;
    logic [7:0]  out_wr;
    logic        en_16_x_baud;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bot_io_ctrl #(
        .N_IN(8), .N_OUT(8), .N_IRQ(4), .BAUD_DIV(54)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .k_write_strobe(k_write_strobe),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .irq_src       (irq_src),
        .in_data       (in_data),
        .rd_pulse      (rd_pulse),
        .out_data      (out_data),
        .out_wr        (out_wr),
        .en_16_x_baud  (en_16_x_baud)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        port_id = addr;
        out_port = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] addr);
        port_id = addr;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL rst_in_port got %h want 00", in_port); end
        checks++; if (out_wr !== 8'h00) begin errors++; $display("FAIL rst_out_wr got %h want 00", out_wr); end
        checks++; if (rd_pulse !== 8'h00) begin errors++; $display("FAIL rst_rd_pulse got %h want 00", rd_pulse); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_interrupt got %b want 0", interrupt); end
        checks++; if (en_16_x_baud !== 1'b0) begin errors++; $display("FAIL rst_baud got %b want 0", en_16_x_baud); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_output();
        wr_reg(8'h23, 8'h5A);
        checks++; if (out_data[31:24] !== 8'h5A) begin errors++; $display("FAIL out_byte3 got %h want 5a", out_data[31:24]); end
        checks++; if (out_wr !== 8'b0000_1000) begin errors++; $display("FAIL out_wr3 got %b want 00001000", out_wr); end
        tick();
        checks++; if (out_wr !== 8'h00) begin errors++; $display("FAIL out_wr3_once got %b want 0", out_wr); end
        port_id = 8'h20; out_port = 8'hA5; k_write_strobe = 1'b1;
        tick();
        k_write_strobe = 1'b0;
        checks++; if (out_wr !== 8'b0000_0001) begin errors++; $display("FAIL kout_wr0 got %b want 00000001", out_wr); end
        checks++; if (out_data !== 64'h0000_0000_5A00_00A5) begin errors++; $display("FAIL out_data got %h want 000000005a0000a5", out_data); end
        wr_reg(8'h28, 8'hFF);
        checks++; if (out_wr !== 8'h00) begin errors++; $display("FAIL out_unmapped got %b want 0", out_wr); end
    endtask

    task automatic test_input();
        port_id = 8'h02; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        checks++; if (in_port !== 8'hC3) begin errors++; $display("FAIL in_port2 got %h want c3", in_port); end
        checks++; if (rd_pulse !== 8'b0000_0100) begin errors++; $display("FAIL rd_pulse2 got %b want 00000100", rd_pulse); end
        tick();
        checks++; if (rd_pulse !== 8'h00) begin errors++; $display("FAIL rd_pulse2_once got %b want 0", rd_pulse); end
        rd_reg(8'h06);
        checks++; if (in_port !== 8'h66) begin errors++; $display("FAIL in_port6 got %h want 66", in_port); end
        rd_reg(8'h3F);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL in_port3f got %h want 00", in_port); end
        rd_reg(8'h08);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL in_port08 got %h want 00", in_port); end
    endtask

    task automatic test_irq_priority();
        wr_reg(8'h11, 8'h0F);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_req got %b want 1", interrupt); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_service got %b want 0", interrupt); end
        rd_reg(8'h12);
        checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL vector1 got %h want 01", in_port); end
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h08) begin errors++; $display("FAIL pending08 got %h want 08", in_port); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        rd_reg(8'h12);
        checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL ack_in_service got %h want 01", in_port); end
        wr_reg(8'h13, 8'h00);
        tick();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rereq got %b want 1", interrupt); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        rd_reg(8'h12);
        checks++; if (in_port !== 8'h03) begin errors++; $display("FAIL vector3 got %h want 03", in_port); end
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL pending00 got %h want 00", in_port); end
        wr_reg(8'h13, 8'h00);
        tick();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", interrupt); end
    endtask

    task automatic test_mask_and_reset();
        wr_reg(8'h11, 8'h00);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL masked_irq got %b want 0", interrupt); end
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h04) begin errors++; $display("FAIL pending04 got %h want 04", in_port); end
        wr_reg(8'h11, 8'h04);
        tick();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b want 1", interrupt); end
        wr_reg(8'h11, 8'h00);
        tick();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_drop got %b want 0", interrupt); end
        wr_reg(8'h11, 8'h04);
        tick();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL remask_irq got %b want 1", interrupt); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_mid_req got %b want 0", interrupt); end
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", in_port); end
        rd_reg(8'h11);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", in_port); end
    endtask

    task automatic test_w1c();
        irq_src = 4'b0001;
        wr_reg(8'h10, 8'h01);
        irq_src = 4'b0000;
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL set_wins got %h want 01", in_port); end
        wr_reg(8'h10, 8'h01);
        rd_reg(8'h10);
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL w1c_clear got %h want 00", in_port); end
    endtask

    task automatic test_baud();
        int n;
        n = 0;
        while (en_16_x_baud !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (en_16_x_baud !== 1'b1) begin errors++; $display("FAIL baud_first got %b want 1 within 300 cycles", en_16_x_baud); end
        tick();
        checks++; if (en_16_x_baud !== 1'b0) begin errors++; $display("FAIL baud_width got %b want 0", en_16_x_baud); end
        n = 1;
        while (en_16_x_baud !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n != 54) begin errors++; $display("FAIL baud_period got %0d want 54", n); end
    endtask

    initial begin
        test_reset();
        test_output();
        test_input();
        test_irq_priority();
        test_mask_and_reset();
        test_w1c();
        test_baud();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
